midi_rx_parser: RTL
===================

MIDI_RX_PARSER -- requirements
Module: midi_rx_parser

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 50000000, meaning the a_clk frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 31250, meaning the MIDI serial bit rate.
REQ-003 The block SHALL have parameter OMNI, default 1; when 1 it accepts all channels.
REQ-004 The block SHALL have parameter CHANNEL, default 0, meaning the accepted channel (0-15) when OMNI=0.
REQ-005 a_clk  input  1  the single clock; every register in the block SHALL be on its rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 midi_rx  input  1  asynchronous serial MIDI line, idle high.
REQ-008 note_number  output  7  key of the last note event.
REQ-009 velocity  output  7  velocity of the last Note On.
REQ-010 pitch  output  14  pitch-bend value, centre 14'h2000.
REQ-011 filter  output  3  filter setting from CC 74.
REQ-012 note_on  output  1  one-cycle pulse per accepted Note On.
REQ-013 note_off  output  1  one-cycle pulse per accepted Note Off.
REQ-014 frame_err  output  1  one-cycle pulse per byte whose stop bit is bad.

Function
REQ-015 midi_rx SHALL pass through a 2-flop synchroniser before any use.
REQ-016 The UART SHALL generate a 16x oversample tick every CLK_HZ/(BAUD*16) a_clk cycles, using integer division.
REQ-017 The UART state machine SHALL use states IDLE, START, DATA, STOP; in IDLE, a synchronised falling edge enters START.
REQ-018 In START, if the line is high at tick 8 the UART SHALL return to IDLE (glitch rejection).
REQ-019 In DATA, the UART SHALL take 8 samples at tick 8 of each bit period, LSB first.
REQ-020 In STOP, the UART SHALL sample at tick 8: a 1 produces a one-cycle byte_valid; a 0 pulses frame_err and drops the byte. Both paths return to IDLE.
REQ-021 The parser SHALL use states NO_STATUS, WAIT_D1, WAIT_D2, and SHALL hold the running status byte.
REQ-022 Bytes 0xF8-0xFF (realtime) SHALL be ignored with no change to state, running status, or the stored first data byte.
REQ-023 Bytes 0xF0-0xF7 SHALL clear running status and enter NO_STATUS; data bytes that follow SHALL be ignored until a new channel status byte arrives.
REQ-024 A channel status byte 0x80-0xEF SHALL be stored as running status and enter WAIT_D1. If OMNI=0 and its channel differs from CHANNEL, the message SHALL be parsed but produce no output.
REQ-025 Message types 0x8n, 0x9n, 0xAn, 0xBn and 0xEn SHALL be two-data-byte messages; 0xCn and 0xDn SHALL be one-data-byte messages.
REQ-026 A data byte in NO_STATUS SHALL be discarded.
REQ-027 After the final data byte, the parser SHALL return to WAIT_D1 (running status).
REQ-028 A status byte that arrives in WAIT_D2 SHALL abandon the partial message and be processed as a new status byte.
REQ-029 Note On with d2>0 SHALL set note_number=d1 and velocity=d2, and pulse note_on.
REQ-030 Note On with d2=0 and Note Off SHALL both set note_number=d1, pulse note_off, and leave velocity unchanged.
REQ-031 Pitch bend SHALL set pitch={d2,d1}, with d2 as the MSBs.
REQ-032 A control change with d1=74 SHALL set filter=d2[6:4]; all other CCs and 0xAn/0xCn/0xDn messages SHALL be ignored.
REQ-033 Output registers SHALL update, and pulses SHALL assert, in the a_clk cycle after the byte_valid of the final data byte; note_on and note_off SHALL never assert together.

Reset
REQ-034 While reset_n=0, the block SHALL force: note_number=0, velocity=0, pitch=14'h2000, filter=0, note_on=0, note_off=0, frame_err=0, UART in IDLE, parser in NO_STATUS, running status cleared.
REQ-035 Assertion of reset_n in the middle of a byte or message SHALL abandon it, and no pulse for it SHALL appear after release.
REQ-036 After release, the first byte SHALL be recognised only from a fresh falling edge.

Structure
REQ-037 Package midi_pkg SHALL hold the status-nibble constants (NOTE_OFF=4'h8, NOTE_ON=4'h9, CC=4'hB, PGM=4'hC, CHPRESS=4'hD, BEND=4'hE), CC_FILTER=7'd74, PITCH_CENTRE=14'h2000, and the UART and parser state enums.
REQ-038 The serial receiver SHALL be the sub-module midi_uart_rx, with outputs byte_data[7:0], byte_valid and frame_err; the parser SHALL be in the top module.

Verification (CLK_HZ=50000000, BAUD=31250, tick divisor 100)
REQ-039 Reset held, then released -> pitch=14'h2000, all pulses 0, and no output change with midi_rx idle for 1 ms.
REQ-040 Serial bytes 0x90 0x3C 0x64 -> exactly one note_on pulse, note_number=60, velocity=100.
REQ-041 Serial bytes 0x90 0x3C 0x64 0x3E 0x00 -> note_on for 60, then note_off with note_number=62 and velocity still 100.
REQ-042 Serial bytes 0xE0 0x7F 0x7F then 0xE0 0x00 0x40 -> pitch=14'h3FFF, then 14'h2000; serial bytes 0xB0 0x4A 0x70 -> filter=3'd7.
REQ-043 Serial bytes 0x90 0x3C 0xF8 0x64 -> a single note_on, note_number=60, velocity=100; serial bytes 0xF0 0x3C 0x64 -> no event.
REQ-044 Serial byte 0x90 sent with stop bit 0, then 0x3C 0x64 -> frame_err pulse and no note event; a 0.25-bit low glitch on midi_rx -> no byte and no frame_err.

Source files
------------

// File: rtl/midi_pkg.sv
// Shared constants, state encodings and small helpers for the MIDI receiver.
package midi_pkg;

  // Status-byte high nibbles
  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] POLY_AT  = 4'hA;
  localparam logic [3:0] CC       = 4'hB;
  localparam logic [3:0] PGM      = 4'hC;
  localparam logic [3:0] CHPRESS  = 4'hD;
  localparam logic [3:0] BEND     = 4'hE;

  localparam logic [6:0]  CC_FILTER    = 7'd74;
  localparam logic [13:0] PITCH_CENTRE = 14'h2000;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

  typedef enum logic [1:0] {
    NO_STATUS,
    WAIT_D1,
    WAIT_D2
  } parse_state_e;

  // Program change and channel pressure carry one data byte; the rest carry two.
  function automatic logic is_one_data(input logic [3:0] nib);
    return (nib == PGM) || (nib == CHPRESS);
  endfunction

endpackage

// File: rtl/midi_uart_rx.sv
// 8N1 serial receiver with 16x oversampling and start-bit glitch rejection.
module midi_uart_rx
  import midi_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 31250
) (
  input  logic       a_clk,
  input  logic       reset_n,
  input  logic       midi_rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int DIV_RAW = CLK_HZ / (BAUD * 16);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;

  uart_state_e   state_q, state_d;
  logic [2:0]    sync_q;
  logic [CW-1:0] div_q, div_d;
  logic [3:0]    sub_q, sub_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          bv_q, bv_d;
  logic          fe_q, fe_d;

  logic rx, fall, tick, samp;

  // Two synchroniser flops plus one history flop for edge detection. They
  // clear to 0 so a line already low at reset release is not mistaken for
  // a start edge; only a real high-to-low transition starts a byte.
  always_ff @(posedge a_clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[1:0], midi_rx};
  end

  assign rx   = sync_q[1];
  assign fall = sync_q[2] & ~sync_q[1];
  assign tick = (div_q == CW'(DIV - 1));
  // Tick 8 of a bit period: sub counter reads 7 on the tick that ends it.
  assign samp = tick && (sub_q == 4'd7);

  // Receiver state register.
  always_ff @(posedge a_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      sub_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      bv_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      sub_q   <= sub_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      bv_q    <= bv_d;
      fe_q    <= fe_d;
    end
  end

  // Next-state: the prescaler and tick counter restart on the start edge so
  // every sample lands at mid-bit.
  always_comb begin
    state_d = state_q;
    div_d   = tick ? '0 : div_q + 1'b1;
    sub_d   = tick ? sub_q + 4'd1 : sub_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    bv_d    = 1'b0;
    fe_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall) begin
          state_d = START;
          div_d   = '0;
          sub_d   = '0;
        end
      end
      START: begin
        if (samp) begin
          if (rx) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            bit_d   = '0;
          end
        end
      end
      DATA: begin
        if (samp) begin
          shift_d = {rx, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (samp) begin
          if (rx) bv_d = 1'b1;
          else    fe_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign byte_data  = shift_q;
  assign byte_valid = bv_q;
  assign frame_err  = fe_q;

endmodule

// File: rtl/midi_rx_parser.sv
// MIDI byte receiver and channel-message parser driving note, pitch-bend and
// filter outputs.
module midi_rx_parser
  import midi_pkg::*;
#(
  parameter int CLK_HZ  = 50000000,
  parameter int BAUD    = 31250,
  parameter int OMNI    = 1,
  parameter int CHANNEL = 0
) (
  input  logic        a_clk,
  input  logic        reset_n,
  input  logic        midi_rx,
  output logic [6:0]  note_number,
  output logic [6:0]  velocity,
  output logic [13:0] pitch,
  output logic [2:0]  filter,
  output logic        note_on,
  output logic        note_off,
  output logic        frame_err
);

  logic [7:0] byte_data;
  logic       byte_valid;

  midi_uart_rx #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) u_uart (
    .a_clk      (a_clk),
    .reset_n    (reset_n),
    .midi_rx    (midi_rx),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .frame_err  (frame_err)
  );

  parse_state_e st_q, st_d;
  logic [7:0]   rs_q, rs_d;
  logic [6:0]   d1_q, d1_d;
  logic [6:0]   nn_q, nn_d;
  logic [6:0]   vel_q, vel_d;
  logic [13:0]  pitch_q, pitch_d;
  logic [2:0]   filt_q, filt_d;
  logic         on_q, on_d;
  logic         off_q, off_d;

  logic       chan_ok;
  logic [6:0] d2;

  // A filtered channel still walks the parser so running status stays in step.
  assign chan_ok = (OMNI != 0) || (rs_q[3:0] == 4'(CHANNEL));
  assign d2      = byte_data[6:0];

  // Parser state and output registers.
  always_ff @(posedge a_clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q    <= NO_STATUS;
      rs_q    <= '0;
      d1_q    <= '0;
      nn_q    <= '0;
      vel_q   <= '0;
      pitch_q <= PITCH_CENTRE;
      filt_q  <= '0;
      on_q    <= 1'b0;
      off_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      rs_q    <= rs_d;
      d1_q    <= d1_d;
      nn_q    <= nn_d;
      vel_q   <= vel_d;
      pitch_q <= pitch_d;
      filt_q  <= filt_d;
      on_q    <= on_d;
      off_q   <= off_d;
    end
  end

  // Byte classification, running status and message completion.
  always_comb begin
    st_d    = st_q;
    rs_d    = rs_q;
    d1_d    = d1_q;
    nn_d    = nn_q;
    vel_d   = vel_q;
    pitch_d = pitch_q;
    filt_d  = filt_q;
    on_d    = 1'b0;
    off_d   = 1'b0;
    if (byte_valid) begin
      if (byte_data >= 8'hF8) begin
        // Realtime bytes may interleave anywhere; they leave everything alone.
      end else if (byte_data >= 8'hF0) begin
        rs_d = '0;
        st_d = NO_STATUS;
      end else if (byte_data[7]) begin
        // New channel status, also abandons any partial message.
        rs_d = byte_data;
        st_d = WAIT_D1;
      end else begin
        case (st_q)
          NO_STATUS: ;
          WAIT_D1: begin
            // One-byte messages complete here and are not acted on.
            if (!is_one_data(rs_q[7:4])) begin
              d1_d = byte_data[6:0];
              st_d = WAIT_D2;
            end
          end
          WAIT_D2: begin
            st_d = WAIT_D1;
            if (chan_ok) begin
              case (rs_q[7:4])
                NOTE_ON: begin
                  nn_d = d1_q;
                  if (d2 != 7'd0) begin
                    vel_d = d2;
                    on_d  = 1'b1;
                  end else begin
                    off_d = 1'b1;
                  end
                end
                NOTE_OFF: begin
                  nn_d  = d1_q;
                  off_d = 1'b1;
                end
                BEND: pitch_d = {d2, d1_q};
                CC: if (d1_q == CC_FILTER) filt_d = d2[6:4];
                default: ;
              endcase
            end
          end
          default: st_d = NO_STATUS;
        endcase
      end
    end
  end

  assign note_number = nn_q;
  assign velocity    = vel_q;
  assign pitch       = pitch_q;
  assign filter      = filt_q;
  assign note_on     = on_q;
  assign note_off    = off_q;

endmodule
